// File: rtl/ahb_mtx_pkg.sv
// Shared AHB bus-matrix encodings and input-stage types.
// Latency: n/a (types only).
// Backpressure: n/a.
package ahb_mtx_pkg;

  // HTRANS encodings
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // HBURST encodings
  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  // HRESP encodings
  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  // Input-stage FSM: whether an address is waiting and/or a data phase is open
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ADDR_HELD = 2'b01,
    ST_DATA      = 2'b10,
    ST_DATA_HELD = 2'b11
  } in_state_e;

  // Address-phase control fields; the address travels beside it so its width stays a parameter
  typedef struct packed {
    logic [1:0] trans;
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic       lock;
  } aphase_ctrl_t;

endpackage

// File: rtl/ahb_mtx_addr_hold_reg.sv
// Hold register for one address phase the output stage could not accept.
// Latency: captured copy and valid flag visible the cycle after the capture edge.
// Backpressure: none itself; caller keeps the master stalled while o_held_valid=1.
module ahb_mtx_addr_hold_reg
  import ahb_mtx_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_capture,
  input  logic              i_release,
  input  logic [ADDR_W-1:0] i_addr,
  input  aphase_ctrl_t      i_ctrl,
  output logic              o_held_valid,
  output logic [ADDR_W-1:0] o_addr,
  output aphase_ctrl_t      o_ctrl
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  aphase_ctrl_t      r_ctrl;

  // Capture on a refused address; drop the valid flag once it is accepted (contents kept)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_ctrl  <= '0;
    end else if (i_capture) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_ctrl  <= i_ctrl;
    end else if (i_release) begin
      r_valid <= 1'b0;
    end
  end

  assign o_held_valid = r_valid;
  assign o_addr       = r_addr;
  assign o_ctrl       = r_ctrl;

endmodule

// File: rtl/ahb_mtx_input_stage.sv
// Per-master AHB matrix input stage: holds a refused address phase, muxes live/held phase to decoder.
// Latency: req_dec and live mux combinational; a held copy is presented from the cycle after capture.
// Backpressure: HREADYOUTS=0 while an address is held; optional AHB_MTX_SEQ_TO_NONSEQ_EN recodes held SEQ.
module ahb_mtx_input_stage
  import ahb_mtx_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int PORT_ID = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic              HRESPS,
  output logic              sel_dec,
  output logic [ADDR_W-1:0] addr_dec,
  output logic [1:0]        trans_dec,
  output logic              write_dec,
  output logic [2:0]        size_dec,
  output logic [2:0]        burst_dec,
  output logic [3:0]        prot_dec,
  output logic              lock_dec,
  output logic              req_dec,
  input  logic              active_dec,
  input  logic              readyout_dec,
  input  logic              resp_dec
);

  logic              w_new_tr;
  logic              w_capture;
  logic              w_release;
  logic              w_held_valid;
  logic [ADDR_W-1:0] w_held_addr;
  aphase_ctrl_t      w_live_ctrl;
  aphase_ctrl_t      w_held_ctrl;
  aphase_ctrl_t      w_pres_ctrl;
  aphase_ctrl_t      w_out_ctrl;
  in_state_e         r_state;

  // NONSEQ/SEQ only; IDLE and BUSY never request and are never held
  assign w_new_tr = HSELS & HTRANSS[1] & HREADYS;

  // The live bus is ignored while a copy is pending, so capture only when nothing is held
  assign w_capture = w_new_tr & ~active_dec & ~w_held_valid;
  assign w_release = w_held_valid & active_dec;

  assign w_live_ctrl = '{trans: HTRANSS, write: HWRITES, size: HSIZES, burst: HBURSTS,
                         prot: HPROTS, lock: HMASTLOCKS};

  ahb_mtx_addr_hold_reg #(
    .ADDR_W (ADDR_W)
  ) u_hold (
    .i_clk        (HCLK),
    .i_rst        (HRESET),
    .i_capture    (w_capture),
    .i_release    (w_release),
    .i_addr       (HADDRS),
    .i_ctrl       (w_live_ctrl),
    .o_held_valid (w_held_valid),
    .o_addr       (w_held_addr),
    .o_ctrl       (w_held_ctrl)
  );

  // Present the held copy while one is pending, otherwise the live bus
  always_comb begin
    w_pres_ctrl = w_held_ctrl;
`ifdef AHB_MTX_SEQ_TO_NONSEQ_EN
    // Grant was lost mid-burst: restart the downstream burst counter from this beat
    if (w_held_ctrl.trans == HTRANS_SEQ) begin
      w_pres_ctrl.trans = HTRANS_NONSEQ;
      w_pres_ctrl.burst = HBURST_INCR;
    end
`endif
    if (w_held_valid) begin
      sel_dec    = 1'b1;
      addr_dec   = w_held_addr;
      w_out_ctrl = w_pres_ctrl;
    end else begin
      sel_dec    = HSELS & HREADYS;
      addr_dec   = HADDRS;
      w_out_ctrl = w_live_ctrl;
    end
  end

  assign trans_dec = w_out_ctrl.trans;
  assign write_dec = w_out_ctrl.write;
  assign size_dec  = w_out_ctrl.size;
  assign burst_dec = w_out_ctrl.burst;
  assign prot_dec  = w_out_ctrl.prot;
  assign lock_dec  = w_out_ctrl.lock;

  // Arbiter registers this, so it may stay combinational
  assign req_dec = ~HRESET & (w_held_valid | w_new_tr);

  // Track pending address and open data phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_new_tr) r_state <= active_dec ? ST_DATA : ST_ADDR_HELD;
        end
        ST_ADDR_HELD: begin
          if (active_dec) r_state <= ST_DATA;
        end
        ST_DATA: begin
          if (readyout_dec) begin
            if (w_new_tr) r_state <= active_dec ? ST_DATA : ST_ADDR_HELD;
            else          r_state <= ST_IDLE;
          end else if (w_new_tr && !active_dec) begin
            r_state <= ST_DATA_HELD;
          end
        end
        ST_DATA_HELD: begin
          // Acceptance of the held address opens its data phase even if the old one is still waiting
          if (active_dec)        r_state <= ST_DATA;
          else if (readyout_dec) r_state <= ST_ADDR_HELD;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Master-side ready/response; IDLE, BUSY and unselected cycles are zero-wait OKAY
  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = HRESP_OKAY;
    if (!HRESET) begin
      case (r_state)
        ST_ADDR_HELD: HREADYOUTS = 1'b0;
        ST_DATA: begin
          HREADYOUTS = readyout_dec;
          HRESPS     = resp_dec;
        end
        ST_DATA_HELD: begin
          HREADYOUTS = 1'b0;
          HRESPS     = resp_dec;
        end
        default: ;
      endcase
    end
  end

  // A held transfer being accepted cannot coincide with a new one: the master is stalled
  a_no_new_while_held: assert property (@(posedge HCLK) disable iff (HRESET)
    !(w_new_tr && active_dec && w_held_valid))
    else $error("ahb_mtx_input_stage port %0d: new transfer while held transfer accepted", PORT_ID);

endmodule

// File: tb/tb_ahb_mtx_input_stage.sv
// Scoreboard bench for ahb_mtx_input_stage: directed scenarios followed by randomized traffic.
// Expected outputs come from a transaction-level model (pending address + open data phase).
// A negedge monitor pops expectations and compares every output.
module tb_ahb_mtx_input_stage;
  import ahb_mtx_pkg::*;

  logic        HCLK;
  logic        HRESET;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic        HRESPS;
  logic        sel_dec;
  logic [31:0] addr_dec;
  logic [1:0]  trans_dec;
  logic        write_dec;
  logic [2:0]  size_dec;
  logic [2:0]  burst_dec;
  logic [3:0]  prot_dec;
  logic        lock_dec;
  logic        req_dec;
  logic        active_dec;
  logic        readyout_dec;
  logic        resp_dec;

  ahb_mtx_input_stage #(.ADDR_W(32), .PORT_ID(0)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
    .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .sel_dec(sel_dec), .addr_dec(addr_dec), .trans_dec(trans_dec), .write_dec(write_dec),
    .size_dec(size_dec), .burst_dec(burst_dec), .prot_dec(prot_dec), .lock_dec(lock_dec),
    .req_dec(req_dec), .active_dec(active_dec), .readyout_dec(readyout_dec), .resp_dec(resp_dec)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic        rdy;
    logic        resp;
    logic        sel;
    logic        req;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
  } exp_t;

  exp_t  q[$];
  string tq[$];
  int    n_vec = 0;
  int    n_bad = 0;

  // Model: an address waiting for acceptance, and whether a target data phase is open
  logic        m_held = 1'b0;
  logic        m_dphase = 1'b0;
  logic [31:0] m_addr = '0;
  logic [1:0]  m_trans = '0;
  logic        m_write = 1'b0;
  logic [2:0]  m_size = '0;
  logic [2:0]  m_burst = '0;
  logic [3:0]  m_prot = '0;
  logic        m_lock = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Compute this cycle's expected outputs, queue them, and wait for the sample point
  task automatic present(input string tag);
    exp_t e;
    logic nt;
    nt = HSELS & HTRANSS[1] & HREADYS;
    e.rdy  = HRESET ? 1'b1 : (m_held ? 1'b0 : (m_dphase ? readyout_dec : 1'b1));
    e.resp = HRESET ? 1'b0 : (m_dphase ? resp_dec : 1'b0);
    e.req  = !HRESET && (m_held || nt);
    e.sel  = m_held || (HSELS && HREADYS);
    if (m_held) begin
      e.addr = m_addr; e.trans = m_trans; e.write = m_write; e.size = m_size;
      e.burst = m_burst; e.prot = m_prot; e.lock = m_lock;
`ifdef AHB_MTX_SEQ_TO_NONSEQ_EN
      if (m_trans == 2'b11) begin
        e.trans = 2'b10;
        e.burst = 3'b001;
      end
`endif
    end else begin
      e.addr = HADDRS; e.trans = HTRANSS; e.write = HWRITES; e.size = HSIZES;
      e.burst = HBURSTS; e.prot = HPROTS; e.lock = HMASTLOCKS;
    end
    q.push_back(e);
    tq.push_back(tag);
    @(negedge HCLK);
  endtask

  // Advance the model across the rising edge, then release inputs for the next cycle
  task automatic advance();
    logic nt;
    logic ndp;
    @(posedge HCLK);
    nt = HSELS & HTRANSS[1] & HREADYS;
    if (HRESET) begin
      m_held = 1'b0; m_dphase = 1'b0; m_addr = '0; m_trans = '0; m_write = 1'b0;
      m_size = '0; m_burst = '0; m_prot = '0; m_lock = 1'b0;
    end else begin
      // A data phase opens when an address is accepted and closes on target ready
      ndp = (active_dec && (nt || m_held)) || (m_dphase && !readyout_dec);
      if (m_held) begin
        if (active_dec) m_held = 1'b0;
      end else if (nt && !active_dec) begin
        m_held = 1'b1; m_addr = HADDRS; m_trans = HTRANSS; m_write = HWRITES;
        m_size = HSIZES; m_burst = HBURSTS; m_prot = HPROTS; m_lock = HMASTLOCKS;
      end
      m_dphase = ndp;
    end
    #1;
  endtask

  task automatic cyc(input string tag);
    present(tag);
    advance();
  endtask

  task automatic idle_bus();
    HRESET = 1'b0; HSELS = 1'b0; HADDRS = '0; HTRANSS = 2'b00; HWRITES = 1'b0;
    HSIZES = 3'b010; HBURSTS = 3'b000; HPROTS = 4'h3; HMASTLOCKS = 1'b0; HREADYS = 1'b1;
    active_dec = 1'b0; readyout_dec = 1'b1; resp_dec = 1'b0;
  endtask

  task automatic nonseq(input logic [31:0] a, input logic wr);
    HSELS = 1'b1; HTRANSS = HTRANS_NONSEQ; HBURSTS = HBURST_SINGLE; HADDRS = a;
    HWRITES = wr; HREADYS = 1'b1;
  endtask

  // Monitor: compare every output against the oldest queued expectation
  always @(negedge HCLK) begin : mon
    exp_t  e;
    exp_t  a;
    string t;
    if (q.size() != 0) begin
      e = q.pop_front();
      t = tq.pop_front();
      a = '{rdy: HREADYOUTS, resp: HRESPS, sel: sel_dec, req: req_dec, addr: addr_dec,
            trans: trans_dec, write: write_dec, size: size_dec, burst: burst_dec,
            prot: prot_dec, lock: lock_dec};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL out[%s] @%0t: got %h required %h (rdy,resp,sel,req,addr,trans,wr,size,burst,prot,lock)",
                 t, $time, a, e);
      end
    end
  end

  initial begin
    idle_bus();
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;

    // Reset state
    present("reset");
    chk("reset_hreadyout", 32'(HREADYOUTS), 32'h1);
    chk("reset_hresp", 32'(HRESPS), 32'h0);
    chk("reset_req", 32'(req_dec), 32'h0);
    advance();
    idle_bus();
    cyc("idle");

    // Granted single
    nonseq(32'h0000_1000, 1'b0);
    active_dec = 1'b1;
    present("grant_addr");
    chk("grant_req", 32'(req_dec), 32'h1);
    chk("grant_addr_dec", addr_dec, 32'h0000_1000);
    advance();
    idle_bus();
    readyout_dec = 1'b0;
    present("grant_data_wait");
    chk("grant_data_rdy0", 32'(HREADYOUTS), 32'h0);
    chk("grant_data_resp", 32'(HRESPS), 32'h0);
    advance();
    readyout_dec = 1'b1;
    present("grant_data_done");
    chk("grant_data_rdy1", 32'(HREADYOUTS), 32'h1);
    advance();

    // Held transfer with the live bus disturbed while waiting
    nonseq(32'h2000_0040, 1'b1);
    cyc("held_cap");
    HADDRS = 32'hDEAD_BEEF;
    HREADYS = 1'b0;
    for (int k = 0; k < 3; k++) begin
      active_dec = (k == 2);
      present("held_wait");
      chk("held_hreadyout", 32'(HREADYOUTS), 32'h0);
      chk("held_addr_dec", addr_dec, 32'h2000_0040);
      chk("held_write_dec", 32'(write_dec), 32'h1);
      advance();
    end
    idle_bus();
    present("held_released");
    chk("held_released_req", 32'(req_dec), 32'h0);
    chk("held_released_rdy", 32'(HREADYOUTS), 32'h1);
    advance();

    // Held SEQ beat of an INCR4 burst
    HSELS = 1'b1; HTRANSS = HTRANS_SEQ; HBURSTS = HBURST_INCR4; HADDRS = 32'h0000_3004;
    HREADYS = 1'b1;
    cyc("seq_cap");
    HREADYS = 1'b0;
    HTRANSS = HTRANS_NONSEQ;
    present("seq_held");
`ifdef AHB_MTX_SEQ_TO_NONSEQ_EN
    chk("seq_trans_dec", 32'(trans_dec), 32'h2);
    chk("seq_burst_dec", 32'(burst_dec), 32'h1);
`else
    chk("seq_trans_dec", 32'(trans_dec), 32'h3);
    chk("seq_burst_dec", 32'(burst_dec), 32'h3);
`endif
    advance();
    active_dec = 1'b1;
    cyc("seq_accept");
    idle_bus();
    cyc("seq_data");

    // Two-cycle ERROR response
    nonseq(32'h0000_5000, 1'b0);
    active_dec = 1'b1;
    cyc("err_addr");
    idle_bus();
    resp_dec = 1'b1; readyout_dec = 1'b0;
    present("err_1");
    chk("err1_resp", 32'(HRESPS), 32'h1);
    chk("err1_rdy", 32'(HREADYOUTS), 32'h0);
    advance();
    readyout_dec = 1'b1;
    present("err_2");
    chk("err2_resp", 32'(HRESPS), 32'h1);
    chk("err2_rdy", 32'(HREADYOUTS), 32'h1);
    advance();
    idle_bus();
    cyc("err_after");

    // Reset while in DATA_HELD
    nonseq(32'h0000_6000, 1'b0);
    active_dec = 1'b1;
    cyc("rst_addr");
    nonseq(32'h0000_6004, 1'b0);
    active_dec = 1'b0; readyout_dec = 1'b0;
    cyc("rst_enter_dh");
    HREADYS = 1'b0; resp_dec = 1'b1;
    present("rst_dh");
    chk("dh_rdy", 32'(HREADYOUTS), 32'h0);
    chk("dh_resp", 32'(HRESPS), 32'h1);
    chk("dh_addr_dec", addr_dec, 32'h0000_6004);
    advance();
    HRESET = 1'b1;
    cyc("rst_edge");
    idle_bus();
    present("rst_after");
    chk("rst_after_rdy", 32'(HREADYOUTS), 32'h1);
    chk("rst_after_resp", 32'(HRESPS), 32'h0);
    chk("rst_after_req", 32'(req_dec), 32'h0);
    advance();

    // IDLE then BUSY while selected
    for (int k = 0; k < 2; k++) begin
      HSELS = 1'b1; HTRANSS = 2'(k); HADDRS = 32'h0000_7000;
      present("idle_busy");
      chk("idle_busy_req", 32'(req_dec), 32'h0);
      chk("idle_busy_rdy", 32'(HREADYOUTS), 32'h1);
      advance();
    end
    idle_bus();
    present("idle_busy_after");
    chk("idle_busy_nostate", 32'(HREADYOUTS), 32'h1);
    advance();

    // Randomized traffic; the master only presents a new address when its HREADY allows
    for (int i = 0; i < 1500; i++) begin
      HRESET       = ($urandom_range(0, 79) == 0);
      HSELS        = ($urandom_range(0, 3) != 0);
      HTRANSS      = 2'($urandom);
      HADDRS       = $urandom;
      HWRITES      = 1'($urandom);
      HSIZES       = 3'($urandom);
      HBURSTS      = 3'($urandom);
      HPROTS       = 4'($urandom);
      HMASTLOCKS   = 1'($urandom);
      readyout_dec = ($urandom_range(0, 3) != 0);
      resp_dec     = ($urandom_range(0, 7) == 0);
      active_dec   = 1'($urandom);
      if (m_held)                          HREADYS = 1'b0;
      else if ($urandom_range(0, 3) == 0)  HREADYS = 1'($urandom);
      else                                 HREADYS = m_dphase ? readyout_dec : 1'b1;
      cyc("rand");
    end

    idle_bus();
    repeat (3) cyc("drain");
    @(negedge HCLK);
    #1;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
